// File: rtl/pll_clk_supervisor.sv
// PLL supervisor: holds the rPLL in reset, waits for a stable lock, checks
// the delivered clock rate against clkin, and only then releases cpu_rst.
//
// Ports:
//   clkin      50 MHz reference clock, the only clock
//   reset      synchronous active-high reset
//   pll_lock   PLL LOCK, asynchronous
//   meas_tog   toggle derived from the PLL output clock, asynchronous
//   pll_reset  drives the PLL RESET input
//   cpu_rst    reset request for the CPU clock domain
//   freq_count transition count of the last completed window
//   freq_valid one-cycle pulse when freq_count updates
//   freq_ok    last window count was within EXP_MIN..EXP_MAX
//   fault      sticky fault after retries run out
//   retry_cnt  retries since the last entry into RUN
module pll_clk_supervisor #(
  parameter int GATE_CYCLES    = 50000,
  parameter int CNT_W          = 16,
  parameter int EXP_MIN        = 2450,
  parameter int EXP_MAX        = 2550,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_SETTLE    = 1024,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             meas_tog,
  output logic             pll_reset,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             freq_ok,
  output logic             fault,
  output logic [1:0]       retry_cnt
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_SETTLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_MEASURE,
    S_RUN,
    S_RETRY,
    S_FAULT
  } state_t;

  state_t state, state_n;

  logic             lock_s1, lock_s;
  logic             tog_s1, tog_s2, tog_s3;
  logic             tog_det;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_sum;
  logic [RW-1:0]    rst_cnt;
  logic [SW-1:0]    run_cnt;
  logic [TW-1:0]    to_cnt;
  logic             in_meas, win_close, sum_ok;
  logic             keep_meas;

  assign tog_det  = tog_s2 ^ tog_s3;
  assign in_meas  = (state == S_MEASURE) || (state == S_RUN);
  assign win_close = in_meas &&
                     (gate_cnt == GW'(GATE_CYCLES - 1));

  // Saturating count that already includes this cycle's transition, so
  // a transition on the closing cycle lands in the closing window.
  assign edge_sum = (tog_det && (edge_cnt != '1)) ?
                    edge_cnt + 1'b1 : edge_cnt;

  assign sum_ok = (edge_sum >= CNT_W'(EXP_MIN)) &&
                  (edge_sum <= CNT_W'(EXP_MAX));

  always_comb begin
    state_n = state;
    unique case (state)
      S_PLL_RST: begin
        if (rst_cnt == RW'(PLL_RST_CYCLES - 1))
          state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s && (run_cnt == SW'(LOCK_SETTLE - 1)))
          state_n = S_MEASURE;
        else if (to_cnt == TW'(LOCK_TIMEOUT - 1))
          state_n = S_RETRY;
      end
      S_MEASURE: begin
        if (!lock_s)
          state_n = S_RETRY;
        else if (win_close)
          state_n = sum_ok ? S_RUN : S_RETRY;
      end
      S_RUN: begin
        if (!lock_s || (win_close && !sum_ok))
          state_n = S_RETRY;
      end
      S_RETRY: begin
        state_n = (retry_cnt == 2'(MAX_RETRY)) ?
                  S_FAULT : S_PLL_RST;
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_PLL_RST;
    endcase
  end

  // Gate and edge counters keep running only while the next state is
  // still a measuring state; any other next state clears them.
  assign keep_meas = in_meas && !win_close &&
                     ((state_n == S_MEASURE) || (state_n == S_RUN));

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= S_PLL_RST;
      lock_s1    <= 1'b0;
      lock_s     <= 1'b0;
      tog_s1     <= 1'b0;
      tog_s2     <= 1'b0;
      tog_s3     <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      rst_cnt    <= '0;
      run_cnt    <= '0;
      to_cnt     <= '0;
      pll_reset  <= 1'b1;
      cpu_rst    <= 1'b1;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_ok    <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s  <= lock_s1;
      tog_s1  <= meas_tog;
      tog_s2  <= tog_s1;
      tog_s3  <= tog_s2;

      state     <= state_n;
      pll_reset <= (state_n == S_PLL_RST) ||
                   (state_n == S_FAULT);
      cpu_rst   <= (state_n != S_RUN);
      fault     <= (state_n == S_FAULT);

      freq_valid <= win_close;
      if (win_close) begin
        freq_count <= edge_sum;
        freq_ok    <= sum_ok;
      end

      if (state_n == S_RUN)
        retry_cnt <= '0;
      else if ((state == S_RETRY) &&
               (state_n == S_PLL_RST))
        retry_cnt <= retry_cnt + 1'b1;

      rst_cnt <= ((state == S_PLL_RST) &&
                  (state_n == S_PLL_RST)) ?
                 rst_cnt + 1'b1 : '0;

      run_cnt <= ((state == S_WAIT_LOCK) &&
                  (state_n == S_WAIT_LOCK) && lock_s) ?
                 run_cnt + 1'b1 : '0;

      to_cnt  <= ((state == S_WAIT_LOCK) &&
                  (state_n == S_WAIT_LOCK)) ?
                 to_cnt + 1'b1 : '0;

      gate_cnt <= keep_meas ? gate_cnt + 1'b1 : '0;
      edge_cnt <= keep_meas ? edge_sum : '0;
    end
  end

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Bench for pll_clk_supervisor: scaled parameters, G-periodic toggle
// patterns, window results checked through an expected-value queue.
module tb_pll_clk_supervisor;

  localparam int G    = 400;
  localparam int N    = 16;
  localparam int S    = 32;
  localparam int T    = 300;
  localparam int EMIN = 49;
  localparam int EMAX = 51;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pll_lock = 1'b0;
  logic        meas_tog = 1'b0;
  logic        pll_reset, cpu_rst;
  logic [15:0] freq_count;
  logic        freq_valid, freq_ok, fault;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k_tog = 0;
  int ph = 0;
  int lock_at = 0;
  int drop_at = -1;
  int inj[3] = '{-1, -1, -1};
  bit chatter = 1'b0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  pll_clk_supervisor #(
    .GATE_CYCLES   (G),
    .CNT_W         (16),
    .EXP_MIN       (EMIN),
    .EXP_MAX       (EMAX),
    .PLL_RST_CYCLES(N),
    .LOCK_SETTLE   (S),
    .LOCK_TIMEOUT  (T),
    .MAX_RETRY     (3)
  ) dut (
    .clkin     (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .meas_tog  (meas_tog),
    .pll_reset (pll_reset),
    .cpu_rst   (cpu_rst),
    .freq_count(freq_count),
    .freq_valid(freq_valid),
    .freq_ok   (freq_ok),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // cyc equals the index of the next posedge after reset release
  always @(posedge clk)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (k_tog > 0 &&
        ((ph + 1) * k_tog / G) != (ph * k_tog / G))
      meas_tog = ~meas_tog;
    foreach (inj[i])
      if (cyc == inj[i]) meas_tog = ~meas_tog;
    ph = (ph + 1) % G;
    pll_lock = (cyc >= lock_at) &&
               !(chatter && (cyc % 25 == 0)) &&
               (cyc != drop_at);
  end

  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (!reset && freq_valid) begin
      chk("valid_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("win_count", freq_count, e[15:0]);
        chk("win_ok", freq_ok, e[16]);
      end
    end
  end

  function automatic void push(input int k, input bit ok);
    exp_q.push_back({ok, 16'(k)});
  endfunction

  task automatic start(input int k, input int l_at);
    @(negedge clk);
    reset   = 1'b1;
    k_tog   = k;
    lock_at = l_at;
    chatter = 1'b0;
    drop_at = -1;
    inj     = '{-1, -1, -1};
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("q_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset();
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_freq_count", freq_count, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_freq_ok", freq_ok, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
  endtask

  initial begin
    int n;
    int bk[3] = '{49, 51, 48};
    reset = 1'b1;
    k_tog = 50;
    repeat (4) @(negedge clk);
    check_reset();

    // nominal start, lock rises at cycle 100
    start(50, 100);
    push(50, 1'b1);
    push(50, 1'b1);
    n = 0;
    while (cpu_rst && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("release_cyc", cyc, 534);
    chk("nom_retry", retry_cnt, 0);
    drain(1000);
    chk("nom_cpu_rst", cpu_rst, 0);
    chk("nom_fault", fault, 0);

    // one-cycle lock drop while running
    drop_at = cyc + 2;
    n = 0;
    while (!cpu_rst && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("loss_latency",
        (cyc - drop_at >= 1) && (cyc - drop_at <= 4), 1);
    n = 0;
    while (!pll_reset && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (pll_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pll_rst_width", n, N);
    chk("loss_retry", retry_cnt, 1);
    push(50, 1'b1);
    drain(1000);
    @(negedge clk);
    chk("relock_cpu_rst", cpu_rst, 0);
    chk("relock_retry", retry_cnt, 0);

    // frequency too high on every attempt
    start(52, 0);
    repeat (4) push(52, 1'b0);
    drain(2500);
    repeat (3) @(negedge clk);
    chk("oor_fault", fault, 1);
    chk("oor_pll_reset", pll_reset, 1);
    chk("oor_cpu_rst", cpu_rst, 1);
    chk("oor_retry", retry_cnt, 3);
    repeat (500) @(negedge clk);
    chk("oor_fault_hold", fault, 1);
    chk("oor_cpu_hold", cpu_rst, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();

    // transitions on the first and the closing cycle of a window
    start(0, 0);
    inj = '{46, 445, 446};
    push(2, 1'b0);
    drain(600);

    // boundary counts
    foreach (bk[i]) begin
      start(bk[i], 0);
      push(bk[i], (bk[i] >= EMIN) && (bk[i] <= EMAX));
      drain(600);
    end

    // lock never asserts
    start(50, 1 << 30);
    n = 0;
    while (!fault && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("nolock_fault_cyc", cyc, 1268);
    chk("nolock_retry", retry_cnt, 3);
    chk("nolock_pll_reset", pll_reset, 1);

    // lock chatter forces a timeout, then stable lock recovers
    start(50, 0);
    chatter = 1'b1;
    n = 0;
    while (retry_cnt == 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("chatter_retry_cyc", cyc, 317);
    chk("chatter_pll_reset", pll_reset, 1);
    chatter = 1'b0;
    push(50, 1'b1);
    drain(1000);
    @(negedge clk);
    chk("chatter_cpu_rst", cpu_rst, 0);
    chk("chatter_retry", retry_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1, "watchdog");
  end

endmodule
